// File: rtl/gray_sweep_pkg.sv
// rtl/gray_sweep_pkg.sv - shared types and Gray-code helpers for the sweep controller
package gray_sweep_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Helpers operate on a 32-bit container; callers zero-extend WIDTH-bit codes.
    localparam int CODE_W_MAX = 32;

    function automatic logic [CODE_W_MAX-1:0] bin2gray(input logic [CODE_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned popcount(input logic [CODE_W_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < CODE_W_MAX; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_adj_check.sv
// rtl/gray_adj_check.sv - sticky checker for Gray mapping and single-bit adjacency
module gray_adj_check
    import gray_sweep_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             chk_en,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] g_new,
    input  logic [WIDTH-1:0] g_prev,
    input  logic             first,
    output logic             err
);

    logic [CODE_W_MAX-1:0] b_ext;
    logic [CODE_W_MAX-1:0] g_new_ext;
    logic [CODE_W_MAX-1:0] g_prev_ext;
    logic                  map_bad;
    logic                  adj_bad;

    assign b_ext      = CODE_W_MAX'(b);
    assign g_new_ext  = CODE_W_MAX'(g_new);
    assign g_prev_ext = CODE_W_MAX'(g_prev);

    // The converter must produce b ^ (b>>1); consecutive results must differ in exactly one bit.
    assign map_bad = (bin2gray(b_ext) != g_new_ext);
    assign adj_bad = (popcount(g_new_ext ^ g_prev_ext) != 1);

    // Sticky error: set by any failing emit, cleared only by reset or an accepted start.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err <= 1'b0;
        end else if (chk_en && (map_bad || (!first && adj_bad))) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/gray_sweep_ctrl.sv
// rtl/gray_sweep_ctrl.sv - sweeps a binary code range through an external Gray converter
module gray_sweep_ctrl
    import gray_sweep_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               step_mode,
    input  logic               step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [WIDTH-1:0]   start_val,
    input  logic [WIDTH-1:0]   end_val,
    output logic [WIDTH-1:0]   b_out,
    input  logic [WIDTH-1:0]   g_in,
    output logic [WIDTH-1:0]   g_out,
    output logic               g_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] lat_dwell;
    logic [WIDTH-1:0]   lat_end;
    logic               lat_step_mode;
    logic               first;

    logic               emit;
    logic               run_emit;
    logic               accept_start;

    // Step mode advances on request; auto mode advances once the dwell count is reached.
    assign emit         = lat_step_mode ? step : (dwell_cnt == lat_dwell);
    assign run_emit     = (state == ST_RUN) && !abort && emit;
    assign accept_start = (state == ST_IDLE) && start;

    // Controller FSM with dwell counter, code counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            b_out         <= '0;
            g_out         <= '0;
            dwell_cnt     <= '0;
            lat_dwell     <= '0;
            lat_end       <= '0;
            lat_step_mode <= 1'b0;
            first         <= 1'b0;
            g_valid       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            g_valid <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_dwell     <= dwell;
                        lat_end       <= end_val;
                        lat_step_mode <= step_mode;
                        b_out         <= start_val;
                        dwell_cnt     <= '0;
                        first         <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // Abort wins over any emit; g_out keeps the last result.
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (emit) begin
                        g_out     <= g_in;
                        g_valid   <= 1'b1;
                        dwell_cnt <= '0;
                        first     <= 1'b0;
                        b_out     <= b_out + WIDTH'(1);
                        if (b_out == lat_end) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else if (!lat_step_mode) begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    gray_adj_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept_start),
        .chk_en (run_emit),
        .b      (b_out),
        .g_new  (g_in),
        .g_prev (g_out),
        .first  (first),
        .err    (err)
    );

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// tb/tb_gray_sweep_ctrl.sv - randomized self-checking bench for gray_sweep_ctrl
module tb_gray_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       step_mode;
    logic       step;
    logic [7:0] dwell;
    logic [3:0] start_val;
    logic [3:0] end_val;
    logic [3:0] b_out;
    logic [3:0] g_in;
    logic [3:0] g_out;
    logic       g_valid;
    logic       busy;
    logic       done;
    logic       err;

    logic       fault_en;
    logic [3:0] fault_code;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_gout = 0;
    int         obs[$];

    always #5 clk = ~clk;

    // External converter, with an optional bit-0 fault on one chosen code.
    assign g_in = (b_out ^ (b_out >> 1)) ^ {3'b000, (fault_en && (b_out == fault_code))};

    gray_sweep_ctrl #(
        .WIDTH   (4),
        .DWELL_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .step_mode (step_mode),
        .step      (step),
        .dwell     (dwell),
        .start_val (start_val),
        .end_val   (end_val),
        .b_out     (b_out),
        .g_in      (g_in),
        .g_out     (g_out),
        .g_valid   (g_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_gray(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    // Runs one sweep from a negedge; the reference is the list of codes the sweep must emit.
    task automatic sweep(input int sv, input int ev, input int dw, input int sm,
                         input int abort_at, input int fault_b);
        int n;
        int c;
        int emitted;
        int budget;
        int exp_g;
        int q[$];
        bit bad;
        bit aborted;
        bit exp_valid;
        bit drv_step;
        bit drv_abort;

        n = ((ev - sv + 16) % 16) + 1;
        q = {};
        for (int i = 0; i < n; i++) q.push_back(model_gray((sv + i) % 16));
        obs = {};
        fault_en   = (fault_b >= 0);
        fault_code = 4'(fault_b);

        start     = 1'b1;
        start_val = 4'(sv);
        end_val   = 4'(ev);
        dwell     = 8'(dw);
        step_mode = sm[0];
        step      = 1'($urandom % 2);
        abort     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        start_val = 4'($urandom);
        end_val   = 4'($urandom);
        dwell     = 8'($urandom);
        step_mode = 1'($urandom % 2);
        check("busy_after_start", int'(busy), 1);
        check("err_cleared", int'(err), 0);
        check("no_valid_at_start", int'(g_valid), 0);

        budget  = (sm != 0) ? 400 : n * (dw + 1) + 4;
        emitted = 0;
        c       = 0;
        bad     = 1'b0;
        aborted = 1'b0;
        while (emitted < n && !aborted && c < budget) begin
            drv_step  = 1'($urandom % 2);
            drv_abort = (abort_at > 0) && (c + 1 == abort_at);
            step      = drv_step;
            abort     = drv_abort;
            start     = ($urandom % 4 == 0);
            @(posedge clk);
            c++;
            if (drv_abort) begin
                aborted   = 1'b1;
                exp_valid = 1'b0;
            end else if (sm != 0) begin
                exp_valid = drv_step;
            end else begin
                exp_valid = (c >= 1 + dw) && (((c - 1 - dw) % (dw + 1)) == 0);
            end
            if (exp_valid) begin
                exp_g = q[emitted];
                if ((sv + emitted) % 16 == fault_b) begin
                    bad   = 1'b1;
                    exp_g = exp_g ^ 1;
                end
                exp_gout = exp_g;
                emitted++;
            end
            @(negedge clk);
            check("g_valid", int'(g_valid), int'(exp_valid));
            check("g_out", int'(g_out), exp_gout);
            check("done", int'(done), int'(exp_valid && emitted == n));
            check("busy", int'(busy), int'(!(aborted || emitted == n)));
            check("err", int'(err), int'(bad));
            check("b_out", int'(b_out), (sv + emitted) % 16);
            if (g_valid) obs.push_back(int'(g_out));
        end
        if (!aborted && emitted < n) check("sweep_timeout", emitted, n);
        start = 1'b0;
        abort = 1'b0;
        step  = 1'b0;
    endtask

    int full_tbl[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    int wrap_tbl[4]  = '{9, 8, 0, 1};
    int dwell_tbl[4] = '{0, 1, 3, 2};

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        step_mode  = 1'b0;
        step       = 1'b0;
        dwell      = '0;
        start_val  = '0;
        end_val    = '0;
        fault_en   = 1'b0;
        fault_code = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_b_out", int'(b_out), 0);
        check("rst_g_out", int'(g_out), 0);
        check("rst_g_valid", int'(g_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full sweep, back-to-back emits
        sweep(0, 15, 0, 0, 0, -1);
        check("full_count", obs.size(), 16);
        for (int i = 0; i < obs.size() && i < 16; i++) check("full_seq", obs[i], full_tbl[i]);
        check("full_err", int'(err), 0);

        // Dwell of nine cycles
        sweep(0, 3, 9, 0, 0, -1);
        check("dwell_count", obs.size(), 4);
        for (int i = 0; i < obs.size() && i < 4; i++) check("dwell_seq", obs[i], dwell_tbl[i]);

        // Wrap-around range
        sweep(14, 1, 0, 0, 0, -1);
        check("wrap_count", obs.size(), 4);
        for (int i = 0; i < obs.size() && i < 4; i++) check("wrap_seq", obs[i], wrap_tbl[i]);

        // Step mode, single-code range; later steps must do nothing
        sweep(5, 5, 0, 1, 0, -1);
        check("step_count", obs.size(), 1);
        if (obs.size() > 0) check("step_code", obs[0], 7);
        for (int i = 0; i < 6; i++) begin
            step = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("idle_step_valid", int'(g_valid), 0);
            check("idle_step_busy", int'(busy), 0);
        end
        step = 1'b0;

        // Abort after five emits, then a clean restart
        sweep(0, 15, 0, 0, 6, -1);
        check("abort_emits", obs.size(), 5);
        check("abort_hold", int'(g_out), 6);
        sweep(2, 6, 1, 0, 0, -1);

        // Converter fault on code 3: err stays set after the sweep, clears on next start
        sweep(0, 7, 1, 0, 0, 3);
        @(negedge clk);
        check("fault_err_sticky", int'(err), 1);
        sweep(0, 7, 0, 0, 0, -1);

        // Reset in the middle of a sweep
        start     = 1'b1;
        start_val = 4'd3;
        end_val   = 4'd12;
        dwell     = 8'd1;
        step_mode = 1'b0;
        fault_en  = 1'b1;
        fault_code = 4'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_b_out", int'(b_out), 0);
        check("midrst_g_out", int'(g_out), 0);
        check("midrst_g_valid", int'(g_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_err", int'(err), 0);
        rst      = 1'b0;
        fault_en = 1'b0;
        exp_gout = 0;
        @(negedge clk);

        // Randomized sweeps
        for (int t = 0; t < 30; t++) begin
            int a_sv;
            int a_ev;
            int a_dw;
            int a_sm;
            int a_ab;
            int a_fb;
            a_sv = int'($urandom % 16);
            a_ev = int'($urandom % 16);
            a_dw = int'($urandom % 6);
            a_sm = int'($urandom % 2);
            a_ab = ($urandom % 4 == 0) ? int'($urandom_range(1, 20)) : 0;
            a_fb = ($urandom % 4 == 0) ? int'($urandom % 16) : -1;
            sweep(a_sv, a_ev, a_dw, a_sm, a_ab, a_fb);
            if ($urandom % 2 == 1) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
